jtframe_ioctl_demux: RTL and testbench
======================================

// Module: jtframe_ioctl_demux
// PURPOSE
// - Parametrised ioctl download demultiplexer between hps_io and the ROM loader.
// - Converts INW-bit download words into byte writes with a valid/ready handshake, replacing the fixed-delay 16-to-8 splitter.
// - Captures DIP bytes (index DIP_IDX) and core_mod (index MOD_IDX) for any INW.
// PARAMETERS
// - INW      8          input word width: 8, 16 or 32; byte lanes NB=INW/8
// - ROM_IDX  8'd0       ioctl_index of ROM downloads
// - DIP_IDX  8'd254     ioctl_index of MRA DIP data
// - MOD_IDX  8'd1       ioctl_index of core_mod byte
// - DIPW     4          DIP bytes captured (1..8)
// - DIP_DEF  all ones   dipsw reset value, 8*DIPW bits
// - MODW     7          core_mod width (1..8)
// - MOD_DEF  7'b01      core_mod reset value
// PORTS
// - clk          in   1       clock (ROM clock domain)
// - rst_n        in   1       synchronous reset, active-low
// - in_download  in   1       hps_io ioctl_download
// - in_index     in   8       hps_io ioctl_index
// - in_wr        in   1       hps_io ioctl_wr, one-cycle strobe
// - in_addr      in   27      hps_io byte address, NB-aligned
// - in_data      in   INW     hps_io data; lowest address in bits [7:0]
// - in_busy      out  1       high while a ROM word is being split
// - downloading  out  1       in_download && in_index==ROM_IDX, registered
// - rom_addr     out  25      byte address of rom_data
// - rom_data     out  8       byte to write
// - rom_wr       out  1       byte valid; held until rom_ok
// - rom_ok       in   1       byte accepted by loader this cycle
// - dipsw        out  8*DIPW  DIP bytes, byte k at [8k+7:8k]
// - core_mod     out  MODW    core options
// - overrun      out  1       sticky: ROM word dropped while busy
// - chksum       out  16      byte sum, only with JTFRAME_IOCTL_CHKSUM_EN
// BEHAVIOUR
// - Reset (rst_n low at clk edge): FSM IDLE, in_busy=0, rom_wr=0, rom_addr=0, rom_data=0,
//   downloading=0, dipsw=DIP_DEF, core_mod=MOD_DEF, overrun=0, chksum=0. Reset mid-split aborts the word.
// - FSM IDLE: in_wr && in_index==ROM_IDX -> latch word and in_addr[24:0]; next cycle rom_wr=1,
//   rom_addr=latched addr, rom_data=lane 0; state SPLIT, in_busy=1.
// - FSM SPLIT: on rom_wr && rom_ok advance lane k -> k+1, rom_addr+1, same cycle update.
//   Accepting lane NB-1 -> rom_wr=0, in_busy=0, IDLE next cycle. No rom_ok -> outputs held stable.
// - Throughput: one byte per cycle with rom_ok tied high; word latency in_wr->first rom_wr = 1 cycle.
// - INW=8: NB=1, one byte per in_wr, same handshake.
// - ROM in_wr while SPLIT: word dropped, overrun set; split in progress unaffected.
// - Rising edge of downloading clears overrun; same-cycle in_wr wins (word latched).
// - DIP: in_wr && in_index==DIP_IDX -> each lane k with in_addr+k < DIPW writes dipsw byte in_addr+k,
//   same cycle; lanes beyond DIPW ignored; no handshake, FSM unaffected.
// - core_mod: in_wr && in_index==MOD_IDX && in_addr==0 -> core_mod <= in_data[MODW-1:0];
//   writes at in_addr!=0 ignored (guards duplicate wide-bus writes).
// - Other indexes: ignored. downloading drops one cycle after in_download falls; pending split completes.
// CONFIGURATION
// - JTFRAME_IOCTL_CHKSUM_EN defined: chksum = 16-bit wrapping sum of every accepted ROM byte
//   (rom_wr && rom_ok); cleared on downloading rising edge. Undefined: chksum tied 0, no adder.
// TESTING
// - INW=16, rom_ok=1, in_wr addr 0x100 data 0xBEEF -> bytes (0x100,0xEF),(0x101,0xBE) on consecutive cycles; in_busy 2 cycles.
// - INW=32, rom_ok low 3 cycles then high, data 0x44332211 at 0x0 -> rom_wr/addr/data held while stalled; bytes 11,22,33,44 at 0..3.
// - INW=16, second ROM in_wr one cycle after first -> second dropped, overrun=1; new download start -> overrun=0.
// - INW=32, DIP_IDX write addr 0 data 0xA5C3_0F81, DIPW=4 -> dipsw=0xA5C30F81; addr 4 write -> dipsw unchanged.
// - INW=16, MOD_IDX writes addr 0 data 0x0003, addr 1 data 0x0000 -> core_mod=7'h03; rst_n low one edge -> 7'h01.
// - CHKSUM_EN, bytes 0xFF x 258 -> chksum=0x00FE wraps correctly; restart -> 0; macro off -> chksum=0.

Source files
------------

// File: rtl/jtframe_ioctl_demux.sv
// ioctl download demultiplexer: splits INW-bit ROM words into handshaked byte writes, captures DIP and core_mod bytes.
// Optional JTFRAME_IOCTL_CHKSUM_EN adds a 16-bit running sum of accepted ROM bytes.
module jtframe_ioctl_demux #(
    parameter int unsigned         INW     = 8,
    parameter logic [7:0]          ROM_IDX = 8'd0,
    parameter logic [7:0]          DIP_IDX = 8'd254,
    parameter logic [7:0]          MOD_IDX = 8'd1,
    parameter int unsigned         DIPW    = 4,
    parameter logic [8*DIPW-1:0]   DIP_DEF = '1,
    parameter int unsigned         MODW    = 7,
    parameter logic [MODW-1:0]     MOD_DEF = MODW'(1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_download,
    input  logic [7:0]          in_index,
    input  logic                in_wr,
    input  logic [26:0]         in_addr,
    input  logic [INW-1:0]      in_data,
    output logic                in_busy,
    output logic                downloading,
    output logic [24:0]         rom_addr,
    output logic [7:0]          rom_data,
    output logic                rom_wr,
    input  logic                rom_ok,
    output logic [8*DIPW-1:0]   dipsw,
    output logic [MODW-1:0]     core_mod,
    output logic                overrun,
    output logic [15:0]         chksum
);

    localparam int unsigned NB = INW / 8;
    localparam int unsigned LW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_active;
    logic [INW-1:0]      r_word;
    logic [LW-1:0]       r_lane;
    logic [24:0]         r_rom_addr;
    logic [7:0]          r_rom_data;
    logic                r_dl;
    logic                r_overrun;
    logic [8*DIPW-1:0]   r_dipsw;
    logic [MODW-1:0]     r_core_mod;

    logic w_rom_sel, w_rom_wr, w_dl_now, w_dl_rise, w_accept, w_last;
    logic w_latch, w_adv, w_done;

    assign w_rom_sel = (in_index == ROM_IDX);
    assign w_rom_wr  = in_wr && w_rom_sel;
    assign w_dl_now  = in_download && w_rom_sel;
    assign w_dl_rise = w_dl_now && !r_dl;
    assign w_accept  = r_active && rom_ok;
    assign w_last    = (r_lane == LW'(NB - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_adv       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rom_wr) begin
                    w_latch     = 1'b1;
                    w_state_nxt = SPLIT;
                end
            end
            SPLIT: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // r_word holds the not-yet-presented lanes, shifted down one byte per accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_word     <= '0;
            r_lane     <= '0;
            r_rom_addr <= '0;
            r_rom_data <= '0;
        end else if (w_latch) begin
            r_active   <= 1'b1;
            r_word     <= in_data >> 8;
            r_lane     <= '0;
            r_rom_addr <= in_addr[24:0];
            r_rom_data <= in_data[7:0];
        end else if (w_adv) begin
            r_word     <= r_word >> 8;
            r_lane     <= r_lane + LW'(1);
            r_rom_addr <= r_rom_addr + 25'd1;
            r_rom_data <= r_word[7:0];
        end else if (w_done) begin
            r_active   <= 1'b0;
        end
    end

    // Setting wins over the download-start clear so a same-cycle drop is not lost
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dl      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_dl <= w_dl_now;
            if (w_rom_wr && r_state == SPLIT) r_overrun <= 1'b1;
            else if (w_dl_rise)               r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dipsw    <= DIP_DEF;
            r_core_mod <= MOD_DEF;
        end else if (in_wr) begin
            if (in_index == DIP_IDX) begin
                for (int unsigned j = 0; j < DIPW; j++) begin
                    for (int unsigned k = 0; k < NB; k++) begin
                        if ({1'b0, in_addr} + 28'(k) == 28'(j))
                            r_dipsw[8*j +: 8] <= in_data[8*k +: 8];
                    end
                end
            end
            if (in_index == MOD_IDX && in_addr == '0)
                r_core_mod <= in_data[MODW-1:0];
        end
    end

`ifdef JTFRAME_IOCTL_CHKSUM_EN
    logic [15:0] r_chksum;

    always_ff @(posedge clk) begin
        if (!rst_n)         r_chksum <= '0;
        else if (w_dl_rise) r_chksum <= '0;
        else if (w_accept)  r_chksum <= r_chksum + {8'd0, r_rom_data};
    end

    assign chksum = r_chksum;
`else
    assign chksum = '0;
`endif

    assign in_busy     = r_active;
    assign rom_wr      = r_active;
    assign rom_addr    = r_rom_addr;
    assign rom_data    = r_rom_data;
    assign downloading = r_dl;
    assign overrun     = r_overrun;
    assign dipsw       = r_dipsw;
    assign core_mod    = r_core_mod;

endmodule

// File: tb/tb_jtframe_ioctl_demux.sv
// Bench for jtframe_ioctl_demux: INW=16 and INW=32 instances on shared ioctl inputs, directed and random ROM/DIP/MOD traffic.
module tb_jtframe_ioctl_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, dl, wr16, wr32, ok16, ok32;
    logic [7:0]  idx;
    logic [26:0] addr;
    logic [31:0] data;

    logic        b16, b32, dn16, dn32, rw16, rw32, ov16, ov32;
    logic [24:0] ra16, ra32;
    logic [7:0]  rd16, rd32;
    logic [31:0] dip16, dip32;
    logic [6:0]  mod16, mod32;
    logic [15:0] cs16, cs32;

    jtframe_ioctl_demux #(.INW(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_download(dl), .in_index(idx), .in_wr(wr16),
        .in_addr(addr), .in_data(data[15:0]), .in_busy(b16), .downloading(dn16),
        .rom_addr(ra16), .rom_data(rd16), .rom_wr(rw16), .rom_ok(ok16),
        .dipsw(dip16), .core_mod(mod16), .overrun(ov16), .chksum(cs16)
    );

    jtframe_ioctl_demux #(.INW(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_download(dl), .in_index(idx), .in_wr(wr32),
        .in_addr(addr), .in_data(data), .in_busy(b32), .downloading(dn32),
        .rom_addr(ra32), .rom_data(rd32), .rom_wr(rw32), .rom_ok(ok32),
        .dipsw(dip32), .core_mod(mod32), .overrun(ov32), .chksum(cs32)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [32:0] q16[$];
    logic [32:0] q32[$];
    logic [15:0] m_cs16, m_cs32;
    logic [7:0]  md[4];

    // Accepted bytes as seen by the loader, {addr, data}
    always @(posedge clk) begin
        if (rst_n && rw16 && ok16) q16.push_back({ra16, rd16});
        if (rst_n && rw32 && ok32) q32.push_back({ra32, rd32});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_cs(input logic [15:0] s);
`ifdef JTFRAME_IOCTL_CHKSUM_EN
        return s;
`else
        return 16'h0 & s;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_busy16", b16, 0);   chk("rst_busy32", b32, 0);
        chk("rst_wr16", rw16, 0);    chk("rst_wr32", rw32, 0);
        chk("rst_addr16", ra16, 0);  chk("rst_data32", rd32, 0);
        chk("rst_dl16", dn16, 0);    chk("rst_ov32", ov32, 0);
        chk("rst_dip16", dip16, 32'hFFFF_FFFF);
        chk("rst_dip32", dip32, 32'hFFFF_FFFF);
        chk("rst_mod16", mod16, 7'h01);
        chk("rst_cs32", cs32, 0);
    endtask

    // Leave then re-enter ROM download so downloading rises
    task automatic restart();
        dl = 1'b0; tick();
        tick();
        chk("dl_low16", dn16, 0);
        dl = 1'b1; idx = 8'd0; tick();
        chk("dl_high16", dn16, 1);
        chk("dl_high32", dn32, 1);
        m_cs16 = '0; m_cs32 = '0;
    endtask

    task automatic word16(input logic [26:0] a, input logic [15:0] d, input bit rnd);
        int i;
        idx = 8'd0; addr = a; data = {16'h0, d}; wr16 = 1'b1;
        tick();
        wr16 = 1'b0;
        i = 0;
        while (b16 && i < 100) begin
            ok16 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            i++;
        end
        ok16 = 1'b1;
        chk("w16_done", b16, 0);
        chk("w16_cnt", q16.size(), 2);
        for (int k = 0; k < 2; k++) begin
            logic [32:0] e;
            logic [7:0]  eb;
            eb = d[8*k +: 8];
            m_cs16 = m_cs16 + {8'd0, eb};
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("w16_byte", e, {a[24:0] + 25'(k), eb});
            end
        end
    endtask

    task automatic word32(input logic [26:0] a, input logic [31:0] d, input bit rnd);
        int i;
        idx = 8'd0; addr = a; data = d; wr32 = 1'b1;
        tick();
        wr32 = 1'b0;
        i = 0;
        while (b32 && i < 200) begin
            ok32 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            i++;
        end
        ok32 = 1'b1;
        chk("w32_done", b32, 0);
        chk("w32_cnt", q32.size(), 4);
        for (int k = 0; k < 4; k++) begin
            logic [32:0] e;
            logic [7:0]  eb;
            eb = d[8*k +: 8];
            m_cs32 = m_cs32 + {8'd0, eb};
            if (q32.size() > 0) begin
                e = q32.pop_front();
                chk("w32_byte", e, {a[24:0] + 25'(k), eb});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; dl = 1'b0; wr16 = 1'b0; wr32 = 1'b0; ok16 = 1'b1; ok32 = 1'b1;
        idx = 8'd0; addr = '0; data = '0;
        m_cs16 = '0; m_cs32 = '0;
        for (int k = 0; k < 4; k++) md[k] = 8'hFF;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_reset();

        // INW=16 split at full throughput
        restart();
        addr = 27'h100; data = 32'h0000_BEEF; wr16 = 1'b1;
        tick(); wr16 = 1'b0;
        chk("s16_wr0", rw16, 1); chk("s16_a0", ra16, 25'h100); chk("s16_d0", rd16, 8'hEF); chk("s16_b0", b16, 1);
        tick();
        chk("s16_wr1", rw16, 1); chk("s16_a1", ra16, 25'h101); chk("s16_d1", rd16, 8'hBE); chk("s16_b1", b16, 1);
        tick();
        chk("s16_b2", b16, 0); chk("s16_wr2", rw16, 0);
        q16.delete();

        // INW=32 with three stalled cycles on lane 0
        ok32 = 1'b0; addr = 27'h0; data = 32'h4433_2211; wr32 = 1'b1;
        tick(); wr32 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("st32_wr", rw32, 1); chk("st32_a", ra32, 25'h0); chk("st32_d", rd32, 8'h11);
            if (s < 2) tick();
        end
        ok32 = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("st32_ak", ra32, 25'(k)); chk("st32_dk", rd32, 8'(8'h11 * (k + 1)));
        end
        tick();
        chk("st32_end", rw32, 0); chk("st32_busy", b32, 0);
        q32.delete();

        // Overrun: second word one cycle after the first
        addr = 27'h200; data = 32'h0000_1234; wr16 = 1'b1;
        tick();
        addr = 27'h202; data = 32'h0000_5678;
        tick(); wr16 = 1'b0;
        chk("ov_set16", ov16, 1); chk("ov_quiet32", ov32, 0);
        tick(); tick();
        chk("ov_cnt", q16.size(), 2);
        if (q16.size() == 2) begin
            chk("ov_b0", q16[0], {25'h200, 8'h34});
            chk("ov_b1", q16[1], {25'h201, 8'h12});
        end
        q16.delete();
        chk("ov_sticky", ov16, 1);
        restart();
        chk("ov_clr", ov16, 0);
        chk("cs_restart16", cs16, 0);

        // Checksum wraps: 258 bytes of 0xFF
        for (int w = 0; w < 129; w++) word16(27'(2 * w), 16'hFFFF, 1'b0);
        chk("cs_model", m_cs16, 16'h00FE);
        chk("cs_wrap16", cs16, exp_cs(16'h00FE));
        restart();
        chk("cs_clr16", cs16, 0);

        // Random words with random backpressure
        for (int r = 0; r < 30; r++) begin
            word32(27'($urandom) & 27'h7FF_FFFC, $urandom, 1'b1);
            word16(27'($urandom) & 27'h7FF_FFFE, 16'($urandom), 1'b1);
        end
        chk("cs_rand16", cs16, exp_cs(m_cs16));
        chk("cs_rand32", cs32, exp_cs(m_cs32));

        // DIP capture
        idx = 8'd254; addr = 27'h0; data = 32'hA5C3_0F81; wr32 = 1'b1;
        tick(); wr32 = 1'b0;
        chk("dip32_w0", dip32, 32'hA5C3_0F81); chk("dip32_fsm", b32, 0);
        addr = 27'h4; data = 32'h1234_5678; wr32 = 1'b1;
        tick(); wr32 = 1'b0;
        chk("dip32_w4", dip32, 32'hA5C3_0F81);
        chk("dip_dl_drop", dn32, 0);
        for (int r = 0; r < 12; r++) begin
            logic [26:0] a;
            logic [15:0] d;
            a = 27'(2 * $urandom_range(0, 3));
            d = 16'($urandom);
            addr = a; data = {16'h0, d}; wr16 = 1'b1;
            tick(); wr16 = 1'b0;
            for (int k = 0; k < 2; k++)
                if (int'(a) + k < 4) md[int'(a) + k] = d[8*k +: 8];
            chk("dip16_rand", dip16, {md[3], md[2], md[1], md[0]});
        end

        // core_mod only from address 0
        idx = 8'd1; addr = 27'h0; data = 32'h0000_0003; wr16 = 1'b1;
        tick(); wr16 = 1'b0;
        chk("mod_a0", mod16, 7'h03);
        addr = 27'h1; data = 32'h0; wr16 = 1'b1;
        tick(); wr16 = 1'b0;
        chk("mod_a1", mod16, 7'h03);
        chk("mod_other", mod32, 7'h01);

        dl = 1'b0; idx = 8'd0;
        rst_n = 1'b0; tick();
        rst_n = 1'b1; tick();
        chk_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
